skew_feeder: RTL and testbench
==============================

Name: skew_feeder

Overview:
- Drains ROWS row buffers through their read side (rd_en / dout / empty) and feeds the systolic array's west edge with diagonal skew.
- Row i starts i cycles after row 0.
- It is the consumer end of the buffer interface. Buffer dout is combinational at the read pointer: the word popped by rd_en is the one visible in the same cycle.
- Sits between the input row buffers and the PE array; one pass moves len words per row.

Parameters:
ROWS, 4, number of row buffers / array rows
DWIDTH, 16, data word width
LEN_W, 8, width of the len input (max len = 2^LEN_W-1)

Ports:
clk  in  1  single clock
rstn  in  1  reset, synchronous, active-high (name kept per codebase convention)
start  in  1  one-cycle pulse; begins a pass when idle
len  in  LEN_W  words per row for this pass; sampled with start
buf_empty  in  ROWS  empty flag from each row buffer
buf_dout  in  ROWS*DWIDTH  dout of each row buffer (row i at [i*DWIDTH +: DWIDTH])
buf_rd_en  out  ROWS  pop strobe per row buffer (combinational)
arr_data  out  ROWS*DWIDTH  registered data to array row i
arr_valid  out  ROWS  registered valid per array row
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: state = IDLE. t, len_q, arr_data, arr_valid, done and busy all 0. buf_rd_en = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start with len != 0, set len_q = len and t = 0, then go to RUN.
  - IDLE: on start with len == 0, go directly to DONE.
  - RUN: when t == len_q + ROWS - 2 and there is no stall, go to DONE.
  - DONE: done = 1 for exactly one cycle, then go to IDLE.
- t width: LEN_W + $clog2(ROWS) + 1 bits, so no overflow.
- Per-row activity: active[i] = (state == RUN) && (t >= i) && (t < i + len_q).
- Stall: stall = OR over i of (active[i] & buf_empty[i]).
  - A stall freezes the whole array to keep the skew.
  - During a stall: t holds, all buf_rd_en = 0, and arr_valid = 0 on the next cycle.
- Pop: buf_rd_en[i] = active[i] & ~stall. This is combinational in the same cycle, so rd_en is never raised on an empty buffer.
- Registered outputs, updated every cycle:
  - arr_valid[i] <= buf_rd_en[i]
  - arr_data[i] <= buf_rd_en[i] ? buf_dout[i] : 0 (zero padding outside the active window)
- Latency:
  - Each word reaches the array 1 cycle after its pop.
  - A pass with no stalls takes len + ROWS - 1 RUN cycles.
  - The last arr_valid (row ROWS-1) coincides with done.
- start while busy: ignored; len is not resampled.
- A simultaneous stall and last-t cycle stays in RUN.
- Reset mid-operation: takes effect at the next edge.
  - Pending words stay in the buffers.
  - No partial done pulse is emitted.

Optional Feature:
SKEW_FEEDER_STALL_CNT_EN
- Defined: adds output stall_cnt[15:0].
  - Counts stall cycles in RUN.
  - Saturates at 16'hFFFF.
  - Cleared on an accepted start and on reset.
  - Holds its value after done.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Config package:
  - typedef enum feeder_state_e {IDLE, RUN, DONE}
  - default DWIDTH constant shared with buffer
- Sub-module feeder_lane, instantiated ROWS times via generate. Each lane holds the active-window compare for its row index and the arr_data/arr_valid register.
- Top level holds the FSM, t, len_q, stall reduction and the optional counter.

Test Plan:
1. ROWS=4, len=3, row i buffer preloaded with i*16+{0,1,2}, never empty; start at cycle 0.
   - RUN lasts cycles 1..6.
   - arr_valid[i] is high in cycles i+2..i+4 with data i*16+0,1,2 in order.
   - done is high only in cycle 7; busy is high in cycles 1..7.
2. Same setup, buf_empty[2] held high for 2 cycles while row 2 is active.
   - All buf_rd_en are 0 in those cycles, and arr_valid is 0 in the following cycles.
   - done is delayed by exactly 2 cycles.
   - Each row's sequence is unchanged: no loss, no duplicates.
3. start with len=0: no buf_rd_en or arr_valid ever asserted; done pulses 1 cycle after start.
4. Second start pulse in mid-RUN:
   - It is ignored and the pass completes with the original len.
   - A start after done runs a fresh pass correctly.
5. rstn asserted at RUN cycle 3:
   - Next cycle: busy, done, arr_valid, buf_rd_en and arr_data are all 0.
   - A new start replays the full skewed sequence from the remaining buffer contents.
6. With SKEW_FEEDER_STALL_CNT_EN defined, scenario 2 gives stall_cnt=2 after done. A following start resets it to 0.

Source files
------------

// File: rtl/skew_feeder_pkg.sv
// Shared types and default sizes for the skew feeder and its row buffers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package skew_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } feeder_state_e;

    // Data width shared with the row buffers feeding this block.
    localparam int DEF_DWIDTH = 16;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/skew_feeder_if.sv
// Read side of the row buffers: per-row pop strobe, empty flag and data word.
// Latency: dout is combinational at the buffer read pointer; the popped word is visible in the pop cycle.
// Backpressure: the consumer never pops a row whose empty flag is set.
interface skew_feeder_if
    import skew_feeder_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int DWIDTH = DEF_DWIDTH
);
    logic [ROWS-1:0]        buf_empty;
    logic [ROWS*DWIDTH-1:0] buf_dout;
    logic [ROWS-1:0]        buf_rd_en;

    // Feeder side: pops the buffers.
    modport master (
        output buf_rd_en,
        input  buf_empty,
        input  buf_dout
    );

    // Buffer side: presents data and empty flags.
    modport slave (
        input  buf_rd_en,
        output buf_empty,
        output buf_dout
    );
endinterface

// File: rtl/skew_feeder_lane.sv
// One array row: active-window compare for this row index plus the output data/valid register.
// Latency: 1 cycle from pop to arr_valid/arr_data.
// Backpressure: a global stall suppresses the pop and drives a zero/invalid beat next cycle.
module feeder_lane #(
    parameter int DWIDTH = 16,
    parameter int TW     = 12,
    parameter int IDX    = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic [TW-1:0]     t,
    input  logic [TW-1:0]     len_ext,
    input  logic              stall,
    input  logic [DWIDTH-1:0] dout,
    output logic              active,
    output logic              rd_en,
    output logic [DWIDTH-1:0] arr_data,
    output logic              arr_valid
);
    localparam logic [TW-1:0] IDX_T = TW'(IDX);

    logic [DWIDTH-1:0] arr_data_q, arr_data_d;
    logic              arr_valid_q, arr_valid_d;

    // Row is inside its skewed window: starts IDX cycles late, lasts len_q words.
    always_comb begin
        active = run && (t >= IDX_T) && (t < IDX_T + len_ext);
        rd_en  = active & ~stall;
    end

    // Zero-pad outside the active window so the array sees clean data.
    always_comb begin
        arr_valid_d = rd_en;
        arr_data_d  = rd_en ? dout : '0;
    end

    // Output register toward the array.
    always_ff @(posedge clk) begin
        if (rstn) begin
            arr_valid_q <= 1'b0;
            arr_data_q  <= '0;
        end else begin
            arr_valid_q <= arr_valid_d;
            arr_data_q  <= arr_data_d;
        end
    end

    assign arr_valid = arr_valid_q;
    assign arr_data  = arr_data_q;
endmodule

// File: rtl/skew_feeder.sv
// Drains ROWS row buffers into the array west edge with row i delayed i cycles; optional stall counter under SKEW_FEEDER_STALL_CNT_EN.
// Latency: word reaches the array 1 cycle after its pop; an unstalled pass runs len+ROWS-1 cycles, then a 1-cycle done.
// Backpressure: any active row whose buffer is empty freezes the whole skew (t holds, no pops).
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    skew_feeder_if.master          buf_if,
    output logic [ROWS*DWIDTH-1:0] arr_data,
    output logic [ROWS-1:0]        arr_valid,
    output logic                   busy,
    output logic                   done
`ifdef SKEW_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);
    // Wide enough for len_q + ROWS - 2 without wrapping.
    localparam int TW = LEN_W + $clog2(ROWS) + 1;

    feeder_state_e    state_q, state_d;
    logic [TW-1:0]    t_q, t_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [TW-1:0]    len_ext;
    logic [TW-1:0]    last_t;
    logic [ROWS-1:0]  active;
    logic [ROWS-1:0]  rd_en;
    logic             run;
    logic             stall;

    assign len_ext = TW'(len_q);
    assign last_t  = len_ext + TW'(ROWS - 2);
    assign run     = (state_q == RUN);

    // One empty active row holds every row so the diagonal stays aligned.
    assign stall            = |(active & buf_if.buf_empty);
    assign buf_if.buf_rd_en = rd_en;

    for (genvar g = 0; g < ROWS; g++) begin : g_lane
        feeder_lane #(
            .DWIDTH (DWIDTH),
            .TW     (TW),
            .IDX    (g)
        ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .run       (run),
            .t         (t_q),
            .len_ext   (len_ext),
            .stall     (stall),
            .dout      (buf_if.buf_dout[g*DWIDTH +: DWIDTH]),
            .active    (active[g]),
            .rd_en     (rd_en[g]),
            .arr_data  (arr_data[g*DWIDTH +: DWIDTH]),
            .arr_valid (arr_valid[g])
        );
    end

    // Pass sequencing: start only accepted in IDLE, t advances only on unstalled cycles.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        t_d     = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    if (t_q == last_t) begin
                        state_d = DONE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, time index and sampled length.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            t_q     <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            len_q   <= len_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of frozen RUN cycles, cleared when a pass is accepted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (run && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder: behavioural row buffers, per-row expected-word scoreboard, done-cycle scoreboard.
// Latency: expected arrival cycles are hand-derived per scenario.
// Backpressure: stalls are forced through the buffer empty flags.
module tb_skew_feeder;
    import skew_feeder_pkg::*;

    localparam int ROWS = 4;
    localparam int DW   = 16;
    localparam int LW   = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [LW-1:0]    len;
    logic [ROWS*DW-1:0] arr_data;
    logic [ROWS-1:0]  arr_valid;
    logic             busy;
    logic             done;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    skew_feeder_if #(.ROWS(ROWS), .DWIDTH(DW)) bus ();

    skew_feeder #(.ROWS(ROWS), .DWIDTH(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .len       (len),
        .buf_if    (bus),
        .arr_data  (arr_data),
        .arr_valid (arr_valid),
        .busy      (busy),
`ifdef SKEW_FEEDER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .done      (done)
    );

    typedef struct {
        int          cyc;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          exp_q [ROWS][$];
    int            done_q[$];
    logic [DW-1:0] buf_q [ROWS][$];

    logic [ROWS-1:0]    q_empty_v;
    logic [ROWS-1:0]    force_empty;
    logic [ROWS-1:0]    pend;
    logic [ROWS*DW-1:0] dout_v;

    assign bus.buf_empty = q_empty_v | force_empty;
    assign bus.buf_dout  = dout_v;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, req);
        end
    endtask

    function automatic void refresh();
        for (int i = 0; i < ROWS; i++) begin
            q_empty_v[i] = (buf_q[i].size() == 0);
            dout_v[i*DW +: DW] = (buf_q[i].size() != 0) ? buf_q[i][0] : '0;
        end
    endfunction

    task automatic load(input int row, input logic [DW-1:0] v);
        buf_q[row].push_back(v);
        refresh();
    endtask

    task automatic expw(input int row, input int c, input logic [DW-1:0] d);
        exp_t e;
        e.cyc = c;
        e.dat = d;
        exp_q[row].push_back(e);
    endtask

    task automatic drained(input string tag);
        for (int i = 0; i < ROWS; i++) begin
            chk($sformatf("%s_row%0d_left", tag, i), 32'(exp_q[i].size()), 0);
        end
        chk($sformatf("%s_done_left", tag), 32'(done_q.size()), 0);
    endtask

    // Behavioural row buffers: pop on each edge where rd_en was high.
    always begin
        @(posedge clk);
        pend = bus.buf_rd_en;
        #1;
        for (int i = 0; i < ROWS; i++) begin
            if (pend[i] && (buf_q[i].size() != 0)) begin
                void'(buf_q[i].pop_front());
            end
        end
        refresh();
    end

    // Monitor: every valid beat must match the next expected word and cycle for its row.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < ROWS; i++) begin
            if (arr_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid row %0d cycle %0d: got data 0x%0h, required no beat",
                             i, cyc, arr_data[i*DW +: DW]);
                end else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("row%0d_cycle", i), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("row%0d_data", i), 32'(arr_data[i*DW +: DW]), 32'(e.dat));
                end
            end else begin
                chk($sformatf("row%0d_pad_zero", i), 32'(arr_data[i*DW +: DW]), 0);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done cycle %0d: got done=1, required 0", cyc);
            end else begin
                chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
        end
    end

    initial begin
        rstn = 1'b1;
        start = 1'b0;
        len = '0;
        force_empty = '0;
        refresh();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(arr_valid), 0);
        chk("rst_data_nz", 32'(arr_data != '0), 0);
        chk("rst_rd_en", 32'(bus.buf_rd_en), 0);
`ifdef SKEW_FEEDER_STALL_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
        rstn = 1'b0;
        @(negedge clk);

        // Scenario 1: len=3, no stalls
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 3; k++) load(i, 16'(i*16 + k));
        b = cyc;
        start = 1'b1;
        len = 8'd3;
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 3; k++) expw(i, b + i + 2 + k, 16'(i*16 + k));
        done_q.push_back(b + 7);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            chk("s1_busy", 32'(busy), 32'((c >= 1) && (c <= 7)));
        end
        drained("s1");

        // Scenario 2: row 2 empty for two cycles at t=3
        @(negedge clk);
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 3; k++) load(i, 16'(i*16 + k));
        b = cyc;
        start = 1'b1;
        len = 8'd3;
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 3; k++)
                expw(i, b + 2 + (i + k) + ((i + k) >= 3 ? 2 : 0), 16'(i*16 + k));
        done_q.push_back(b + 9);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 4) force_empty = 4'b0100;
            if (c == 6) force_empty = 4'b0000;
            if (c == 4 || c == 5) begin
                #1;
                chk("s2_stall_rd_en", 32'(bus.buf_rd_en), 0);
            end
            if (c == 5 || c == 6) chk("s2_stall_valid", 32'(arr_valid), 0);
            chk("s2_busy", 32'(busy), 32'((c >= 1) && (c <= 9)));
        end
`ifdef SKEW_FEEDER_STALL_CNT_EN
        chk("s2_stall_cnt", 32'(stall_cnt), 2);
`endif
        drained("s2");

        // Scenario 3: len=0 pass, buffers hold one word each that must stay
        @(negedge clk);
        for (int i = 0; i < ROWS; i++) load(i, 16'(16'h00A0 + i));
        b = cyc;
        start = 1'b1;
        len = 8'd0;
        done_q.push_back(b + 1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            #1;
            chk("s3_rd_en", 32'(bus.buf_rd_en), 0);
            chk("s3_valid", 32'(arr_valid), 0);
            chk("s3_busy", 32'(busy), 32'(c == 1));
`ifdef SKEW_FEEDER_STALL_CNT_EN
            if (c == 1) chk("s3_stall_cnt_clr", 32'(stall_cnt), 0);
`endif
        end
        chk("s3_words_kept", 32'(buf_q[0].size() + buf_q[1].size() + buf_q[2].size() + buf_q[3].size()), 4);
        drained("s3");

        // Scenario 4: len=2 pass with a second start mid-RUN, then a fresh len=1 pass
        @(negedge clk);
        for (int i = 0; i < ROWS; i++) load(i, 16'(16'h00B0 + i));
        b = cyc;
        start = 1'b1;
        len = 8'd2;
        for (int i = 0; i < ROWS; i++) begin
            expw(i, b + i + 2, 16'(16'h00A0 + i));
            expw(i, b + i + 3, 16'(16'h00B0 + i));
        end
        done_q.push_back(b + 6);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) begin
                start = 1'b1;
                len = 8'd5;
            end
            if (c == 4) begin
                start = 1'b0;
                len = 8'd0;
            end
            chk("s4_busy", 32'(busy), 32'((c >= 1) && (c <= 6)));
        end
        drained("s4a");
        @(negedge clk);
        for (int i = 0; i < ROWS; i++) load(i, 16'(16'h00C0 + i));
        b = cyc;
        start = 1'b1;
        len = 8'd1;
        for (int i = 0; i < ROWS; i++) expw(i, b + i + 2, 16'(16'h00C0 + i));
        done_q.push_back(b + 5);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            chk("s4b_busy", 32'(busy), 32'((c >= 1) && (c <= 5)));
        end
        drained("s4b");

        // Scenario 5: reset during the third RUN cycle, then replay from leftovers
        @(negedge clk);
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 3; k++) load(i, 16'(16'h0D00 + i*16 + k));
        b = cyc;
        start = 1'b1;
        len = 8'd3;
        expw(0, b + 2, 16'h0D00);
        expw(0, b + 3, 16'h0D01);
        expw(1, b + 3, 16'h0D10);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c < 3) chk("s5_busy", 32'(busy), 32'(c >= 1));
            if (c == 3) rstn = 1'b1;
            if (c == 4) begin
                chk("s5_rst_busy", 32'(busy), 0);
                chk("s5_rst_done", 32'(done), 0);
                chk("s5_rst_valid", 32'(arr_valid), 0);
                chk("s5_rst_data_nz", 32'(arr_data != '0), 0);
                chk("s5_rst_rd_en", 32'(bus.buf_rd_en), 0);
                rstn = 1'b0;
            end
        end
        drained("s5a");
        // Rows popped 3,2,1,0 words before reset; top each back up to 3 words.
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < 3 - i; j++) load(i, 16'(16'h0E00 + i*16 + j));
        @(negedge clk);
        b = cyc;
        start = 1'b1;
        len = 8'd3;
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < 3; k++)
                expw(i, b + i + 2 + k,
                     (k < i) ? 16'(16'h0D00 + i*16 + (3 - i) + k) : 16'(16'h0E00 + i*16 + (k - i)));
        done_q.push_back(b + 7);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) start = 1'b0;
            chk("s5b_busy", 32'(busy), 32'((c >= 1) && (c <= 7)));
        end
        drained("s5b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
